joy_db9md_scan: RTL and testbench
=================================

// Module: joy_db9md_scan
// PURPOSE
// - N-port generalisation of the DB9 Mega Drive pad reader for arcade cores; sits between USER_IN/USER_OUT SNAC pins and the core's joystick_N muxes.
// - Time-multiplexes NUM_PORTS pads on one shared 6-bit input bus and runs the full 8-phase TH protocol per port.
// - Classifies each pad as 6-button MD, 3-button MD or Atari/SMS, and publishes active-high button words.
// PARAMETERS
// - NUM_PORTS  2       pads scanned (1..4)
// - CLK_HZ     40e6    clk frequency, Hz
// - PHASE_US   10      settle time per TH phase; PHASE_CYC=CLK_HZ*PHASE_US/1e6
// - FRAME_US   2000    scan period; FRAME_CYC=CLK_HZ*FRAME_US/1e6; must exceed NUM_PORTS*9*PHASE_US
// PORTS
// - clk          in   1               system clock (clk_sys)
// - reset_n      in   1               asynchronous, active-low reset
// - joy_in       in   6               active-low: [0]U [1]D [2]L [3]R [4]TL [5]TR
// - joy_mdsel    out  1               TH select, shared by all ports
// - port_sel     out  max(1,clog2(N)) selected port; bit0 == legacy joy_split when N=2
// - joystick     out  12*NUM_PORTS    per port, active-high: [0]R [1]L [2]D [3]U [4]B [5]C [6]A [7]Start [8]Mode [9]X [10]Y [11]Z
// - md_det       out  NUM_PORTS       1 = MD signature seen on last commit
// - six_btn      out  NUM_PORTS       1 = 6-button signature seen
// - update       out  NUM_PORTS       1-cycle pulse when that port's word commits
// BEHAVIOUR
// - Reset: joy_mdsel=1, port_sel=0, joystick=0, md_det=0, six_btn=0, update=0, FSM=IDLE, frame counter=0.
// - joy_in is double-flop synchronised before use; the 2-cycle latency sits inside PHASE_CYC.
// - Frame counter: free-running 0..FRAME_CYC-1. Tick when count==FRAME_CYC-1.
// - IDLE: joy_mdsel=1. On tick: port_sel=0, go to SETTLE.
// - SETTLE: hold PHASE_CYC cycles with joy_mdsel=1, then go to PHASE with ph=0.
// - PHASE ph=0..7: TH = 1 on even ph, 0 on odd ph.
//   - Each phase lasts PHASE_CYC cycles. Sample on the last cycle, then toggle joy_mdsel.
//   - ph0 (H): U D L R B(TL) C(TR).
//   - ph1 (L): A(TL) Start(TR). md = (L low and R low).
//   - ph5 (L): six = md and U,D,L,R all low.
//   - ph6 (H): if six, Z=U X=... mapping Z=U, Y=D, X=L, Mode=R.
//   - ph2,3,4,7: ignored.
// - COMMIT (1 cycle):
//   - Write the port's word, md_det and six_btn; pulse update[port]; return joy_mdsel to 1.
//   - If port_sel<NUM_PORTS-1: increment port_sel, go to SETTLE. Else: port_sel=0, go to IDLE.
// - Word rules:
//   - !md (Atari/SMS): bits[5:0] from ph0 only; bits[11:6]=0.
//   - md && !six: bits[11:8]=0.
// - Ticks arriving outside IDLE are dropped; the scan is never restarted mid-port.
// - Outputs of other ports hold their values while one port is scanned; commit is atomic per port.
// - Reset asserted mid-scan: all outputs return to reset values asynchronously; the scan restarts from IDLE.
// CONFIGURATION
// - DB9MD_DEBOUNCE_EN defined: per port, keep the last raw word.
//   - Commit joystick/md_det/six_btn only when two consecutive scans match; update pulses only on an actual commit.
//   - Shadow words reset to 0.
// - DB9MD_DEBOUNCE_EN undefined: every scan commits directly; no shadow registers.
// TESTING
// - Setup: CLK_HZ=40e6, PHASE_US=10 (400 cyc), FRAME_US=2000 (80000 cyc), N=2. Pad model drives joy_in from joy_mdsel/port_sel.
// - T1 reset: reset_n low -> joy_mdsel=1, port_sel=0, joystick=0. First update[0] at 80000+400+8*400+1 cycles after release.
// - T2 6-btn pad on port0 holding A+Z -> joystick[11:0]=0x840, md_det[0]=1, six_btn[0]=1.
// - T3 3-btn pad holding Start+Up -> 0x088, md_det=1, six_btn=0.
// - T4 Atari pad (L,R high in ph1) holding Right+TL -> 0x011, md_det=0, six_btn=0.
// - T5 port1 pad holding B, port0 idle -> joystick[23:12]=0x010, joystick[11:0]=0; port_sel toggles 0->1->0 per frame.
// - T6 reset_n pulsed low during ph3 of port1 -> all outputs 0 immediately; next frame scans cleanly from port0.
// - T7 (DB9MD_DEBOUNCE_EN) press B for exactly one scan -> no commit; hold 2 scans -> 0x010 on 2nd update.

Source files
------------

// File: rtl/joy_db9md_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | joy_db9md_scan : NUM_PORTS-way DB9 Mega Drive pad scanner, 8-phase TH.    |
// | Option macro DB9MD_DEBOUNCE_EN : commit only after two matching scans.    |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
module joy_db9md_scan #(
   parameter int  NUM_PORTS = 2,
   parameter int  CLK_HZ    = 40_000_000,
   parameter int  PHASE_US  = 10,
   parameter int  FRAME_US  = 2000,
   localparam int PSW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [5:0]              joy_in,
   output logic                    joy_mdsel,
   output logic [PSW-1:0]          port_sel,
   output logic [12*NUM_PORTS-1:0] joystick,
   output logic [NUM_PORTS-1:0]    md_det,
   output logic [NUM_PORTS-1:0]    six_btn,
   output logic [NUM_PORTS-1:0]    update
);

   localparam int PHASE_CYC = int'((64'(CLK_HZ) * 64'(PHASE_US)) / 64'd1_000_000);
   localparam int FRAME_CYC = int'((64'(CLK_HZ) * 64'(FRAME_US)) / 64'd1_000_000);
   localparam int PCW       = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
   localparam int FCW       = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
   localparam int WBITS     = 12 * NUM_PORTS;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_PHASE  = 2'd2,
      S_COMMIT = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [FCW-1:0]       frame_q;
   logic [PCW-1:0]       cnt_q, cnt_d;
   logic [2:0]           ph_q, ph_d;
   logic [PSW-1:0]       port_q, port_d;
   logic [5:0]           sync1_q, sync2_q;
   logic [11:0]          raw_q, raw_d;
   logic                 md_q, md_d;
   logic                 six_q, six_d;
   logic                 mdsel_q, mdsel_d;
   logic [WBITS-1:0]     joy_q, joy_d;
   logic [NUM_PORTS-1:0] mddet_q, mddet_d;
   logic [NUM_PORTS-1:0] sixbtn_q, sixbtn_d;
   logic [NUM_PORTS-1:0] update_q, update_d;

   logic                 w_tick;
   logic                 w_last;
   logic [5:0]           w_act;
   logic [11:0]          w_word;
   logic                 w_commit;

   assign w_tick = (frame_q == FCW'(FRAME_CYC - 1));
   assign w_last = (cnt_q == PCW'(PHASE_CYC - 1));
   assign w_act  = ~sync2_q;

   // Atari/SMS pads only own the ph0 bits; 3-button pads have no X/Y/Z/Mode.
   assign w_word = md_q ? (six_q ? raw_q : {4'b0000, raw_q[7:0]})
                        : {6'b000000, raw_q[5:0]};

`ifdef DB9MD_DEBOUNCE_EN
   logic [13:0] shadow_q [NUM_PORTS];
   logic [13:0] shadow_d [NUM_PORTS];

   assign w_commit = (shadow_q[port_q] == {six_q, md_q, w_word});

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_PORTS; i++) shadow_q[i] <= '0;
      end else begin
         shadow_q <= shadow_d;
      end
   end
`else
   assign w_commit = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_q <= '0;
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         frame_q <= w_tick ? '0 : frame_q + FCW'(1);
         sync1_q <= joy_in;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         ph_q     <= '0;
         port_q   <= '0;
         raw_q    <= '0;
         md_q     <= 1'b0;
         six_q    <= 1'b0;
         mdsel_q  <= 1'b1;
         joy_q    <= '0;
         mddet_q  <= '0;
         sixbtn_q <= '0;
         update_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ph_q     <= ph_d;
         port_q   <= port_d;
         raw_q    <= raw_d;
         md_q     <= md_d;
         six_q    <= six_d;
         mdsel_q  <= mdsel_d;
         joy_q    <= joy_d;
         mddet_q  <= mddet_d;
         sixbtn_q <= sixbtn_d;
         update_q <= update_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ph_d     = ph_q;
      port_d   = port_q;
      raw_d    = raw_q;
      md_d     = md_q;
      six_d    = six_q;
      joy_d    = joy_q;
      mddet_d  = mddet_q;
      sixbtn_d = sixbtn_q;
      update_d = '0;
`ifdef DB9MD_DEBOUNCE_EN
      shadow_d = shadow_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (w_tick) begin
               port_d  = '0;
               cnt_d   = '0;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (w_last) begin
               cnt_d   = '0;
               ph_d    = '0;
               state_d = S_PHASE;
            end else begin
               cnt_d = cnt_q + PCW'(1);
            end
         end
         S_PHASE: begin
            if (w_last) begin
               cnt_d = '0;
               case (ph_q)
                  3'd0: raw_d[5:0] = {w_act[5], w_act[4], w_act[0],
                                      w_act[1], w_act[2], w_act[3]};
                  3'd1: begin
                     raw_d[7:6] = {w_act[5], w_act[4]};
                     md_d       = (sync2_q[3:2] == 2'b00);
                  end
                  3'd5: six_d = md_q && (sync2_q[3:0] == 4'b0000);
                  3'd6: raw_d[11:8] = {w_act[0], w_act[1], w_act[2], w_act[3]};
                  default: ;
               endcase
               if (ph_q == 3'd7) begin
                  state_d = S_COMMIT;
               end else begin
                  ph_d = ph_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + PCW'(1);
            end
         end
         S_COMMIT: begin
            if (w_commit) begin
               joy_d[12*port_q +: 12] = w_word;
               mddet_d[port_q]        = md_q;
               sixbtn_d[port_q]       = six_q;
               update_d[port_q]       = 1'b1;
            end
`ifdef DB9MD_DEBOUNCE_EN
            shadow_d[port_q] = {six_q, md_q, w_word};
`endif
            ph_d = '0;
            if (port_q == PSW'(NUM_PORTS - 1)) begin
               port_d  = '0;
               state_d = S_IDLE;
            end else begin
               port_d  = port_q + PSW'(1);
               cnt_d   = '0;
               state_d = S_SETTLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // TH is registered from the next state so the pad sees clean edges.
      mdsel_d = !((state_d == S_PHASE) && ph_d[0]);
   end

   assign joy_mdsel = mdsel_q;
   assign port_sel  = port_q;
   assign joystick  = joy_q;
   assign md_det    = mddet_q;
   assign six_btn   = sixbtn_q;
   assign update    = update_q;

endmodule
`default_nettype wire

// File: tb/tb_joy_db9md_scan.sv
`default_nettype none
// Bench for joy_db9md_scan: TH-edge-counting pad models plus a timeline model.
module tb_joy_db9md_scan;
   localparam int N = 2;
   localparam int P = 20;          // 2 MHz * 10 us
   localparam int F = 500;         // 2 MHz * 250 us
   localparam int S = 9 * P + 1;   // settle + 8 phases + commit

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [5:0]      joy_in;
   logic            joy_mdsel;
   logic [0:0]      port_sel;
   logic [12*N-1:0] joystick;
   logic [N-1:0]    md_det;
   logic [N-1:0]    six_btn;
   logic [N-1:0]    update;

   int total = 0;
   int bad   = 0;
   int cyc;
   int tc = 0;
   int          ptype [N];
   logic [11:0] pbtn  [N];
   logic [11:0] exp_word [N];
   logic        exp_md   [N];
   logic        exp_six  [N];
   logic [13:0] shadow   [N];

   joy_db9md_scan #(
      .NUM_PORTS(N),
      .CLK_HZ   (2_000_000),
      .PHASE_US (10),
      .FRAME_US (250)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .joy_in   (joy_in),
      .joy_mdsel(joy_mdsel),
      .port_sel (port_sel),
      .joystick (joystick),
      .md_det   (md_det),
      .six_btn  (six_btn),
      .update   (update)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   // Pad protocol position: count TH edges, wrap after the 8th.
   always @(joy_mdsel or negedge reset_n) begin
      if (!reset_n) tc = 0;
      else          tc = (tc + 1) % 8;
   end

   // type 0 = Atari/SMS, 1 = 3-button MD, 2 = 6-button MD
   function automatic logic [5:0] pad_drive(input int t, input logic [11:0] b, input int ph);
      logic u, d, l, r, bb, c, a, st;
      {r, l, d, u, bb, c, a, st} = {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
      if (t == 0) return ~{c, bb, r, l, d, u};
      if (ph % 2 == 0) begin
         if (t == 2 && ph == 6) return ~{c, bb, b[8], b[9], b[10], b[11]};
         return ~{c, bb, r, l, d, u};
      end
      if (t == 2 && ph == 5) return {~st, ~a, 4'b0000};
      if (t == 2 && ph == 7) return {~st, ~a, 4'b1111};
      return {~st, ~a, 2'b00, ~d, ~u};
   endfunction

   always_comb joy_in = pad_drive(ptype[port_sel], pbtn[port_sel], tc);

   // {six, md, word} a pad of this type and button set must produce
   function automatic logic [13:0] scan_result(input int t, input logic [11:0] b);
      case (t)
         0:       return {2'b00, 6'b000000, b[5:0]};
         1:       return {2'b01, 4'b0000, b[7:0]};
         default: return {2'b11, b};
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp_v, cyc);
      end
   endtask

   always @(negedge clk) begin : model_cmp
      logic [13:0]     nw;
      logic [N-1:0]    eu, em, es;
      logic [12*N-1:0] ej;
      int              t, pp, r, esel;
      logic            eth;
      if (!reset_n) begin
         for (int p = 0; p < N; p++) begin
            exp_word[p] = '0;
            exp_md[p]   = 1'b0;
            exp_six[p]  = 1'b0;
            shadow[p]   = '0;
         end
      end else begin
         eu = '0;
         for (int p = 0; p < N; p++) begin
            if (cyc >= F && (cyc % F) == (p + 1) * S) begin
               nw = scan_result(ptype[p], pbtn[p]);
`ifdef DB9MD_DEBOUNCE_EN
               if (nw == shadow[p]) begin
                  {exp_six[p], exp_md[p], exp_word[p]} = nw;
                  eu[p] = 1'b1;
               end
               shadow[p] = nw;
`else
               {exp_six[p], exp_md[p], exp_word[p]} = nw;
               eu[p] = 1'b1;
`endif
            end
         end
         t    = cyc % F;
         eth  = 1'b1;
         esel = 0;
         if (cyc >= F && t < N * S) begin
            pp   = t / S;
            r    = t - pp * S;
            esel = pp;
            if (r >= P && r < 9 * P && ((r - P) / P) % 2 == 1) eth = 1'b0;
         end
         for (int p = 0; p < N; p++) begin
            ej[12*p +: 12] = exp_word[p];
            em[p]          = exp_md[p];
            es[p]          = exp_six[p];
         end
         chk("joy_mdsel", 32'(joy_mdsel), 32'(eth));
         chk("port_sel",  32'(port_sel),  32'(esel));
         chk("update",    32'(update),    32'(eu));
         chk("joystick",  32'(joystick),  32'(ej));
         chk("md_det",    32'(md_det),    32'(em));
         chk("six_btn",   32'(six_btn),   32'(es));
      end
   end

   task automatic wait_cyc(input int target);
      int guard;
      guard = 0;
      while (cyc < target && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc < target) begin
         total++;
         bad++;
         $display("FAIL wait_cyc: got cyc %0d required %0d", cyc, target);
      end
   endtask

   task automatic after_frame(input int f);
      wait_cyc(f * F + N * S + 2);
   endtask

   task automatic set_pad(input int p, input int t, input logic [11:0] b);
      ptype[p] = t;
      pbtn[p]  = b;
   endtask

   task automatic rand_pad(input int p);
      int t;
      logic [11:0] b;
      t = int'($urandom_range(0, 2));
      b = 12'($urandom);
      if (t == 0 && b[1] && b[0]) b[0] = 1'b0;
      if (t == 1 && b[3] && b[2]) b[2] = 1'b0;
      set_pad(p, t, b);
   endtask

   task automatic wait_first_update;
      for (int i = 0; i < 4 * F && !update[0]; i++) @(negedge clk);
      chk("first_update_cyc", 32'(cyc), 32'd681);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_mdsel"},    32'(joy_mdsel), 32'd1);
      chk({tag, "_port_sel"}, 32'(port_sel),  32'd0);
      chk({tag, "_joystick"}, 32'(joystick),  32'd0);
      chk({tag, "_md_det"},   32'(md_det),    32'd0);
      chk({tag, "_six_btn"},  32'(six_btn),   32'd0);
      chk({tag, "_update"},   32'(update),    32'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation still running, required finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      set_pad(0, 0, 12'h000);
      set_pad(1, 0, 12'h000);
      repeat (3) @(negedge clk);
      #1;
      check_reset_state("reset");
      reset_n = 1'b1;
      wait_first_update();

      after_frame(1);
      set_pad(0, 2, 12'h840);   // A + Z on 6-button pad
      set_pad(1, 1, 12'h088);   // Start + Up on 3-button pad
      after_frame(3);
      chk("t2_word",  32'(joystick[11:0]),  32'h840);
      chk("t3_word",  32'(joystick[23:12]), 32'h088);
      chk("t23_md",   32'(md_det),          32'h3);
      chk("t23_six",  32'(six_btn),         32'h1);

      set_pad(0, 0, 12'h011);   // Atari Right + TL
      set_pad(1, 2, 12'h010);   // B on port 1
      after_frame(5);
      chk("t45_word", 32'(joystick),        32'h010011);
      chk("t45_md",   32'(md_det),          32'h2);
      chk("t45_six",  32'(six_btn),         32'h2);

      for (int k = 0; k < 10; k++) begin
         rand_pad(0);
         rand_pad(1);
         after_frame(7 + 2 * k);
      end

      // Reset pulsed during port 1, phase 3 of frame 26.
      wait_cyc(26 * F + S + 4 * P + P / 2);
      #2 reset_n = 1'b0;
      #1 check_reset_state("midreset");
      set_pad(0, 0, 12'h000);
      set_pad(1, 0, 12'h000);
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b1;
      wait_first_update();
      chk("restart_update", 32'(update), 32'h1);
      after_frame(1);
      set_pad(0, 2, 12'h840);
      after_frame(3);
      chk("restart_word", 32'(joystick[11:0]), 32'h840);

`ifdef DB9MD_DEBOUNCE_EN
      set_pad(0, 1, 12'h000);
      after_frame(5);
      set_pad(0, 1, 12'h010);   // B for exactly one scan
      after_frame(6);
      set_pad(0, 1, 12'h000);
      after_frame(7);
      chk("t7_glitch_word", 32'(joystick[11:0]), 32'h000);
      set_pad(0, 1, 12'h010);   // B held for two scans
      wait_cyc(8 * F + S);
      chk("t7_first_update", 32'(update[0]), 32'd0);
      wait_cyc(9 * F + S);
      chk("t7_second_update", 32'(update[0]), 32'd1);
      chk("t7_held_word", 32'(joystick[11:0]), 32'h010);
`endif

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
